// File: rtl/result_readback.sv
// Result buffer reader: fetches word_count 4-bit results from SRAM (one per word),
// packs four nibbles per 16-bit output word and streams them over valid/ready.
module result_readback #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rdr_sram_read_address,
    input  logic [DATA_W-1:0] sram_rdr_read_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        dbg_state
);

    // out_valid/out_data follow valid/ready: a word transfers on any rising edge where
    // both are high; while out_valid is high and out_ready low, out_data and the
    // address stay frozen, and out_valid only drops after a transfer (or reset).
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_WAIT = 3'd2,
        S_EMIT = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [CNT_W-1:0]    r_remaining;
    logic [1:0]          r_nib_idx;
    logic [DATA_W-1:0]   r_pack;
    logic [DATA_W-1:0]   r_out_data;
    logic                r_out_valid;
    logic                r_busy;
    logic                r_done;

    logic [DATA_W-1:0]   w_pack_next;
    logic                w_last_nib;
    logic [DATA_W-5:0]   w_unused_hi;

    // Only the low nibble of each result word carries data.
    assign w_unused_hi = sram_rdr_read_data[DATA_W-1:4];

    always_comb begin
        w_pack_next = r_pack;
        w_pack_next[{r_nib_idx, 2'b00} +: 4] = sram_rdr_read_data[3:0];
    end

    // The word closes when its fourth slot fills or the job runs out of nibbles.
    assign w_last_nib = (r_nib_idx == 2'd3) || (r_remaining == CNT_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_nib_idx   <= '0;
            r_pack      <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr      <= base_addr;
                        r_remaining <= word_count;
                        r_nib_idx   <= '0;
                        r_pack      <= '0;
                        r_busy      <= 1'b1;
                        if (word_count == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_pack      <= w_pack_next;
                    r_addr      <= r_addr + ADDR_W'(1);
                    r_remaining <= r_remaining - CNT_W'(1);
                    r_nib_idx   <= r_nib_idx + 2'd1;
                    if (w_last_nib) begin
                        r_state     <= S_EMIT;
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_pack_next;
                    end else begin
                        r_state <= S_READ;
                    end
                end
                S_EMIT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_out_data  <= '0;
                        r_pack      <= '0;
                        r_nib_idx   <= '0;
                        if (r_remaining == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_READ;
                        end
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy                  = r_busy;
    assign done                  = r_done;
    assign rdr_sram_read_address = r_addr;
    assign out_data              = r_out_data;
    assign out_valid             = r_out_valid;
    assign dbg_state             = r_state;

endmodule

// File: tb/tb_result_readback.sv
// Bench for result_readback: table of jobs with hand-packed expected words,
// a synchronous SRAM model, plus hand-written reset sequences.
module tb_result_readback;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [11:0] base_addr;
    logic [11:0] word_count;
    logic        busy;
    logic        done;
    logic [11:0] addr;
    logic [15:0] rdata;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] mem [0:4095];

    always #5 clk = ~clk;

    // Synchronous-read SRAM: data is valid one cycle after the address.
    always @(posedge clk) rdata <= mem[addr];

    result_readback dut (
        .clk                   (clk),
        .reset                 (reset),
        .start                 (start),
        .base_addr             (base_addr),
        .word_count            (word_count),
        .busy                  (busy),
        .done                  (done),
        .rdr_sram_read_address (addr),
        .sram_rdr_read_data    (rdata),
        .out_data              (out_data),
        .out_valid             (out_valid),
        .out_ready             (out_ready),
        .dbg_state             (dbg_state)
    );

    typedef struct {
        logic [11:0] base;
        logic [11:0] cnt;
        int          stall;
        int          restart_at;
        int          nwords;
        logic [15:0] w0;
        logic [15:0] w1;
        int          lat;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_job(input vec_t v);
        logic [15:0] exp_q[$];
        logic [11:0] addr_q[$];
        int          cyc = 0;
        int          words = 0;
        int          viol = 0;
        int          addr_err = 0;
        int          done_cnt = 0;
        int          done_idx = -1;
        int          first_valid = -1;
        int          stall_left;
        bit          hold_valid = 1'b0;
        bit          finished = 1'b0;
        logic [15:0] hold_data = '0;
        logic [11:0] hold_addr = '0;

        if (v.nwords > 0) exp_q.push_back(v.w0);
        if (v.nwords > 1) exp_q.push_back(v.w1);
        for (int i = 0; i < int'(v.cnt); i++) addr_q.push_back(v.base + 12'(i));

        @(posedge clk); #1;
        start = 1'b1; base_addr = v.base; word_count = v.cnt; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_on_accept", busy, 1);
        stall_left = v.stall;

        while (!finished && cyc < 300) begin
            start = 1'b0;
            if (cyc == v.restart_at) begin
                start = 1'b1; base_addr = 12'h100; word_count = 12'd6;
            end
            if (done) begin
                done_cnt++;
                if (done_cnt == 1) done_idx = cyc;
            end
            if (done && out_valid) viol++;
            if (!out_valid && out_data != 16'h0) viol++;
            if (dbg_state == 3'd2) begin
                if (addr_q.size() == 0) addr_err++;
                else if (addr != addr_q.pop_front()) addr_err++;
            end
            if (out_valid) begin
                if (first_valid < 0) first_valid = cyc;
                if (hold_valid && (out_data != hold_data || addr != hold_addr)) viol++;
                if (stall_left > 0) begin
                    out_ready = 1'b0;
                    if (!hold_valid) begin
                        hold_valid = 1'b1; hold_data = out_data; hold_addr = addr;
                    end
                    stall_left--;
                end else begin
                    out_ready = 1'b1;
                    words++;
                    if (exp_q.size() == 0) viol++;
                    else check("packed_word", out_data, exp_q.pop_front());
                    stall_left = v.stall;
                    hold_valid = 1'b0;
                end
            end else begin
                out_ready = 1'b1;
            end
            if (done_cnt > 0 && cyc > done_idx) finished = 1'b1;
            else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        start = 1'b0;

        check("job_finished", finished, 1);
        check("done_pulses", done_cnt, 1);
        check("busy_after_done", busy, 0);
        check("word_total", words, v.nwords);
        check("protocol_viol", viol, 0);
        check("addr_seq_err", addr_err + addr_q.size(), 0);
        if (v.nwords == 0) begin
            check("empty_done_idx", done_idx, 0);
            check("empty_no_valid", first_valid, 32'hFFFF_FFFF);
        end else begin
            check("first_valid_lat", first_valid, v.lat);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_addr"}, addr, 0);
        check({tag, "_data"}, out_data, 0);
        check({tag, "_state"}, dbg_state, 0);
    endtask

    initial begin
        int wait_cyc;
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0;
        mem[12'h010] = 16'h0001; mem[12'h011] = 16'h0002;
        mem[12'h012] = 16'h0003; mem[12'h013] = 16'h0004;
        for (int i = 0; i < 6; i++) mem[12'h100 + i] = 16'hFFFA + 16'(i);
        mem[12'hFFE] = 16'h0005; mem[12'hFFF] = 16'h0006;
        mem[12'h000] = 16'h0007; mem[12'h001] = 16'h0008;
        mem[12'h200] = 16'hFFF9;

        //          base     cnt    stall restart nwords w0        w1        lat
        vecs[0] = '{12'h010, 12'd4, 0,    -1,     1,     16'h4321, 16'h0000, 8};
        vecs[1] = '{12'h100, 12'd6, 0,    -1,     2,     16'hDCBA, 16'h00FE, 8};
        vecs[2] = '{12'h010, 12'd4, 5,    -1,     1,     16'h4321, 16'h0000, 8};
        vecs[3] = '{12'hFFE, 12'd4, 0,    -1,     1,     16'h8765, 16'h0000, 8};
        vecs[4] = '{12'h050, 12'd0, 0,    0,      0,     16'h0000, 16'h0000, -1};
        vecs[5] = '{12'h200, 12'd1, 0,    -1,     1,     16'h0009, 16'h0000, 2};
        vecs[6] = '{12'h010, 12'd4, 2,    2,      1,     16'h4321, 16'h0000, 8};

        reset = 1'b1; start = 1'b0; base_addr = '0; word_count = '0; out_ready = 1'b1;
        #12;
        check_all_zero("reset");
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 7; i++) run_job(vecs[i]);

        // Reset asserted while a word is waiting in EMIT clears outputs without an edge.
        @(posedge clk); #1;
        start = 1'b1; base_addr = 12'h010; word_count = 12'd4; out_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        wait_cyc = 0;
        while (!out_valid && wait_cyc < 50) begin
            @(posedge clk); #1;
            wait_cyc++;
        end
        check("valid_before_reset", out_valid, 1);
        check("busy_before_reset", busy, 1);
        #2 reset = 1'b1;
        #1 check_all_zero("mid_reset");
        @(posedge clk); #1;
        reset = 1'b0; out_ready = 1'b1;
        run_job(vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
